// File: rtl/data_ram_be_if.sv
// Request/response bundle for the byte-enable data RAM.
// The master drives requests and the slave returns read data, status and error pulses.
interface data_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  Mem_Req;
    logic                  Mem_Write;
    logic [ADDR_W-1:0]     Mem_Addr;
    logic [DATA_W/8-1:0]   Mem_BE;
    logic [DATA_W-1:0]     M_W_Data;
    logic [DATA_W-1:0]     M_R_Data;
    logic                  M_R_Valid;
    logic                  Mem_Ready;
    logic                  Mem_Err;

    modport master (
        output Mem_Req, Mem_Write, Mem_Addr, Mem_BE, M_W_Data,
        input  M_R_Data, M_R_Valid, Mem_Ready, Mem_Err
    );

    modport slave (
        input  Mem_Req, Mem_Write, Mem_Addr, Mem_BE, M_W_Data,
        output M_R_Data, M_R_Valid, Mem_Ready, Mem_Err
    );
endinterface

// File: rtl/data_ram_be.sv
// Word RAM with byte-lane writes that zeroes itself after every reset before accepting requests.
// Latency: reads return one cycle after the request edge; writes take effect on the request edge.
// Backpressure: none in RUN (one operation per cycle); Mem_Ready stays low during the DEPTH-cycle clear.
module data_ram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    data_ram_be_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFS   = $clog2(BE_W);
    localparam int IDX_W = ADDR_W - OFS;
    localparam int CNT_W = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [CNT_W-1:0]    init_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    word_idx;
    logic [CNT_W-1:0]    mem_idx;
    logic                legal;
    logic                accept;

    assign word_idx = bus.Mem_Addr[ADDR_W-1:OFS];
    assign mem_idx  = word_idx[CNT_W-1:0];
    // Extra top bit keeps the range test exact when DEPTH fills the whole index space.
    assign legal    = (bus.Mem_Addr[OFS-1:0] == '0) &&
                      ({1'b0, word_idx} < (IDX_W+1)'(DEPTH));
    assign accept   = (state == RUN) && bus.Mem_Req;

    // Array has no reset: contents are zeroed only by the INIT sweep.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_idx] <= '0;
        end else if (accept && bus.Mem_Write && legal) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.Mem_BE[i]) begin
                    mem[mem_idx][8*i +: 8] <= bus.M_W_Data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_idx      <= '0;
            bus.M_R_Data  <= '0;
            bus.M_R_Valid <= 1'b0;
            bus.Mem_Ready <= 1'b0;
            bus.Mem_Err   <= 1'b0;
        end else begin
            bus.M_R_Valid <= 1'b0;
            bus.Mem_Err   <= 1'b0;
            case (state)
                INIT: begin
                    if (init_idx == CNT_W'(DEPTH - 1)) begin
                        state         <= RUN;
                        bus.Mem_Ready <= 1'b1;
                    end else begin
                        init_idx <= init_idx + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (bus.Mem_Req) begin
                        bus.Mem_Err <= !legal;
                        if (!bus.Mem_Write) begin
                            bus.M_R_Valid <= 1'b1;
                            bus.M_R_Data  <= legal ? mem[mem_idx] : '0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram_be.sv
// Scoreboard bench: two instances (DEPTH 64 and 48) share one random request stream;
// a reference model queues expected responses and a negedge monitor checks them.
module tb_data_ram_be;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_ram_be_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
    data_ram_be_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

    data_ram_be #(.DATA_W(32), .DEPTH(64), .ADDR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    data_ram_be #(.DATA_W(32), .DEPTH(48), .ADDR_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_b.Mem_Req   = bus_a.Mem_Req;
    assign bus_b.Mem_Write = bus_a.Mem_Write;
    assign bus_b.Mem_Addr  = bus_a.Mem_Addr;
    assign bus_b.Mem_BE    = bus_a.Mem_BE;
    assign bus_b.M_W_Data  = bus_a.M_W_Data;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] m_a [64];
    logic [31:0] m_b [64];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Reference: a word is addressable when aligned and inside the instance's depth.
    task automatic model(input int w, input bit wr, input logic [7:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        int          depth;
        int          idx;
        bit          ok;
        logic [31:0] word;
        exp_t        e;
        depth = (w == 0) ? 64 : 48;
        idx   = int'(addr) / 4;
        ok    = (addr % 4 == 0) && (idx < depth);
        word  = (w == 0) ? m_a[idx] : m_b[idx];
        e.cyc  = cyc + 1;
        e.rd   = !wr;
        e.err  = !ok;
        e.data = ok ? word : 32'h0;
        if (wr && ok) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            if (w == 0) m_a[idx] = word;
            else        m_b[idx] = word;
        end
        if (!wr || !ok) begin
            if (w == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
    endtask

    task automatic op(input bit wr, input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
        bus_a.Mem_Req   = 1'b1;
        bus_a.Mem_Write = wr;
        bus_a.Mem_Addr  = addr;
        bus_a.Mem_BE    = be;
        bus_a.M_W_Data  = wd;
        model(0, wr, addr, be, wd);
        model(1, wr, addr, be, wd);
        @(negedge clk);
        bus_a.Mem_Req = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_a.Mem_Req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mon(input int w, input logic [31:0] d, input logic v, input logic e);
        exp_t x;
        bit   have;
        string tag;
        tag = (w == 0) ? "a" : "b";
        if (v || e) begin
            have = (w == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL spurious_%s got valid=%0b err=%0b want none", tag, v, e);
            end else begin
                x = (w == 0) ? q_a.pop_front() : q_b.pop_front();
                chk({"resp_cycle_", tag}, 32'(cyc), 32'(x.cyc));
                chk({"valid_", tag}, {31'b0, v}, {31'b0, x.rd});
                chk({"err_", tag}, {31'b0, e}, {31'b0, x.err});
                if (x.rd) begin
                    chk({"rdata_", tag}, d, x.data);
                    if (w == 0) last_a = x.data;
                    else        last_b = x.data;
                end
            end
        end else begin
            chk({"hold_", tag}, d, (w == 0) ? last_a : last_b);
            have = (w == 0) ? (q_a.size() > 0 && q_a[0].cyc <= cyc)
                            : (q_b.size() > 0 && q_b[0].cyc <= cyc);
            if (have) begin
                checks++;
                errors++;
                if (w == 0) void'(q_a.pop_front());
                else        void'(q_b.pop_front());
                $display("FAIL missing_%s got no response want response at cycle %0d", tag, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus_a.M_R_Data, bus_a.M_R_Valid, bus_a.Mem_Err);
            mon(1, bus_b.M_R_Data, bus_b.M_R_Valid, bus_b.Mem_Err);
        end
    end

    task automatic reset_checks();
        chk("rst_rdata_a", bus_a.M_R_Data, 32'h0);
        chk("rst_valid_a", {31'b0, bus_a.M_R_Valid}, 32'h0);
        chk("rst_ready_a", {31'b0, bus_a.Mem_Ready}, 32'h0);
        chk("rst_err_a",   {31'b0, bus_a.Mem_Err}, 32'h0);
        chk("rst_rdata_b", bus_b.M_R_Data, 32'h0);
        chk("rst_valid_b", {31'b0, bus_b.M_R_Valid}, 32'h0);
        chk("rst_ready_b", {31'b0, bus_b.Mem_Ready}, 32'h0);
        chk("rst_err_b",   {31'b0, bus_b.Mem_Err}, 32'h0);
        for (int i = 0; i < 64; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        last_a = '0;
        last_b = '0;
        q_a.delete();
        q_b.delete();
    endtask

    // Counts edges from release until Mem_Ready, throwing requests at the block while it clears.
    task automatic init_sweep();
        int first_a;
        int first_b;
        first_a = 0;
        first_b = 0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (bus_a.Mem_Ready && first_a == 0) first_a = n;
            if (bus_b.Mem_Ready && first_b == 0) first_b = n;
            if (n < 40) begin
                bus_a.Mem_Req   = 1'($urandom_range(0, 1));
                bus_a.Mem_Write = 1'($urandom_range(0, 1));
                bus_a.Mem_Addr  = 8'($urandom_range(0, 255));
                bus_a.Mem_BE    = 4'($urandom);
                bus_a.M_W_Data  = $urandom;
            end else begin
                bus_a.Mem_Req = 1'b0;
            end
        end
        chk("ready_edges_a", 32'(first_a), 32'd64);
        chk("ready_edges_b", 32'(first_b), 32'd48);
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++)
            op(1'b0, 8'(i * 4), 4'($urandom), $urandom);
    endtask

    initial begin
        logic [7:0] addr;
        bus_a.Mem_Req   = 1'b0;
        bus_a.Mem_Write = 1'b0;
        bus_a.Mem_Addr  = '0;
        bus_a.Mem_BE    = '0;
        bus_a.M_W_Data  = '0;

        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        init_sweep();
        read_all();

        op(1'b1, 8'h00, 4'hF, 32'hAAAAAAAA);
        op(1'b0, 8'h00, 4'h0, 32'h0);
        op(1'b1, 8'h00, 4'b0101, 32'h11223344);
        op(1'b0, 8'h00, 4'hF, 32'h0);
        op(1'b0, 8'h04, 4'hF, 32'h0);

        op(1'b0, 8'h02, 4'hF, 32'h0);
        bus_a.Mem_Write = 1'b1;
        bus_a.Mem_Addr  = 8'h04;
        bus_a.Mem_BE    = 4'hF;
        bus_a.M_W_Data  = 32'hDEADBEEF;
        @(negedge clk);
        op(1'b0, 8'h04, 4'hF, 32'h0);

        op(1'b0, 8'hC0, 4'hF, 32'h0);
        op(1'b1, 8'hC0, 4'hF, 32'hCAFEF00D);
        op(1'b1, 8'hFC, 4'hF, 32'h12345678);
        op(1'b1, 8'hBC, 4'hF, 32'h87654321);
        op(1'b1, 8'h07, 4'hF, 32'h55555555);
        op(1'b0, 8'hBC, 4'h0, 32'h0);
        op(1'b0, 8'hFC, 4'h0, 32'h0);
        read_all();

        for (int k = 0; k < 400; k++) begin
            addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            op(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        read_all();
        idle(3);

        op(1'b1, 8'h10, 4'hF, 32'h0BADF00D);
        idle(2);
        #1 rst_n = 1'b0;
        #1 reset_checks();
        #2 rst_n = 1'b1;
        init_sweep();
        read_all();
        idle(3);

        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram_be.md
DATA_RAM_BE -- requirements
Module: data_ram_be

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, word width in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL provide parameter DEPTH, default 64, number of words; legal range is 2..2^(ADDR_W-OFS).
REQ-003 SHALL provide parameter ADDR_W, default 8, byte-address width; OFS = log2(DATA_W/8) is derived, not a parameter.
REQ-004 SHALL have ports, in order:
  clk        in   1          rising-edge clock
  rst_n      in   1          async reset, active-low
  Mem_Req    in   1          operation request, sampled on clk rising edge
  Mem_Write  in   1          1 = write, 0 = read; meaningful only with Mem_Req
  Mem_Addr   in   ADDR_W     byte address
  Mem_BE     in   DATA_W/8   byte-lane write enables; bit i covers bits [8i+7:8i]
  M_W_Data   in   DATA_W     write data
  M_R_Data   out  DATA_W     registered read data
  M_R_Valid  out  1          one-cycle pulse: M_R_Data updated this cycle
  Mem_Ready  out  1          1 = initialisation done, requests accepted
  Mem_Err    out  1          one-cycle pulse: the last accepted request was illegal
REQ-005 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-006 SHALL implement a two-state FSM: INIT and RUN.
REQ-007 In INIT, an index counter SHALL clear one word to zero per rising edge, starting at word 0 and ending at word DEPTH-1.
REQ-008 On the edge that clears word DEPTH-1, the FSM SHALL enter RUN and Mem_Ready SHALL go to 1; Mem_Ready is therefore high after exactly DEPTH edges following rst_n release.
REQ-009 In INIT, Mem_Req SHALL be ignored: no write, no M_R_Valid, no Mem_Err.
REQ-010 Word index SHALL be Mem_Addr[ADDR_W-1:OFS].
REQ-011 A request is illegal if Mem_Addr[OFS-1:0] != 0 (misaligned) or if the word index >= DEPTH.
REQ-012 For a legal write in RUN, on the edge, only lanes with Mem_BE[i]=1 SHALL be updated; other lanes SHALL be kept. Mem_BE=0 SHALL be a legal no-op write.
REQ-013 For a legal read in RUN, on the edge, M_R_Data SHALL load the addressed word and M_R_Valid SHALL be 1 for one cycle (1-cycle latency).
REQ-014 Mem_BE SHALL be ignored for reads; a read always returns the full word.
REQ-015 For an illegal write, memory SHALL be unchanged and Mem_Err SHALL pulse for one cycle.
REQ-016 For an illegal read, M_R_Data SHALL load 0, and M_R_Valid and Mem_Err SHALL both pulse for one cycle.
REQ-017 M_R_Data SHALL hold its value between reads; writes, including to the last-read address, SHALL NOT change it.
REQ-018 Back-to-back requests SHALL be accepted every cycle in RUN; write-then-read of the same word on consecutive edges SHALL return the new data.
REQ-019 Exactly one operation SHALL occur per cycle; the block SHALL have no internal queue and no stall in RUN.

Reset
REQ-020 While rst_n=0: FSM=INIT, index counter=0, M_R_Data=0, M_R_Valid=0, Mem_Ready=0, Mem_Err=0, all taking effect immediately.
REQ-021 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight operation; after release, a full DEPTH-cycle clear SHALL run again, so all words read 0.
REQ-022 Memory contents SHALL NOT be cleared asynchronously; zeroing occurs only through the INIT sweep.

Verification
REQ-023 Defaults: release rst_n, count edges -> Mem_Ready=1 after exactly 64 edges; reading every word 0..63 returns 0x00000000.
REQ-024 Write addr 0x00 data 0xAAAAAAAA BE=4'hF, then read 0x00 on the next cycle -> M_R_Data=0xAAAAAAAA, M_R_Valid pulses one cycle later.
REQ-025 After REQ-024: write 0x00 data 0x11223344 BE=4'b0101, read 0x00 -> 0xAA22AA44; read 0x04 -> 0x00000000.
REQ-026 Read 0x02 (misaligned), then write 0x04 with Mem_Req held 0 -> read: M_R_Data=0, M_R_Valid=1, Mem_Err=1; word 1 still 0.
REQ-027 DEPTH=48, read 0xC0 (index 48) -> Mem_Err=1, M_R_Data=0; write 0xC0 -> Mem_Err=1, words 0..47 unchanged.
REQ-028 Pulse rst_n low for 3 ns mid-RUN after writing nonzero data -> outputs 0 immediately, Mem_Ready low for 64 edges, then all words read 0; Mem_Req during INIT has no effect.
